// File: rtl/program_sequencer.sv
// rtl/program_sequencer.sv - fetch/sequence controller for the 4-bit accumulator core
// Three cycles per instruction (FETCH, WAIT, EXEC); skip-if-nonzero resolved here.
module program_sequencer #(
  parameter int unsigned LAST_ADDR = 15,
  parameter bit          WRAP      = 1'b1,
  parameter logic [3:0]  SNZA_OP   = 4'b1000,
  parameter logic [3:0]  SNZS_OP   = 4'b1001
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic       step,
  input  logic       restart,
  input  logic       zero_a,
  input  logic       zero_s,
  output logic [3:0] rom_addr,
  input  logic [3:0] rom_data,
  output logic [3:0] op,
  output logic       exec_valid,
  output logic [3:0] pc,
  output logic       busy,
  output logic       halted
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WAIT, S_EXEC, S_HALT
  } state_t;

  localparam logic [4:0] LAST5 = 5'(LAST_ADDR);

  state_t     state_q, state_d;
  logic [3:0] pc_q, pc_d;
  logic [3:0] op_q, op_d;
  logic       halted_q, halted_d;
  logic       single_q, single_d;
  logic       skip;
  logic       end_hit;
  logic [4:0] nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      pc_q     <= 4'd0;
      op_q     <= 4'b0111;
      halted_q <= 1'b0;
      single_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      op_q     <= op_d;
      halted_q <= halted_d;
      single_q <= single_d;
    end
  end

  always_comb begin
    skip     = ((op_q == SNZA_OP) && !zero_a) || ((op_q == SNZS_OP) && !zero_s);
    nxt      = {1'b0, pc_q} + (skip ? 5'd2 : 5'd1);
    end_hit  = nxt > LAST5;
    state_d  = state_q;
    pc_d     = pc_q;
    op_d     = op_q;
    halted_d = halted_q;
    single_d = single_q;
    // restart overrides everything, including the EXEC pc update
    if (restart) begin
      state_d  = S_IDLE;
      pc_d     = 4'd0;
      halted_d = 1'b0;
      single_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (run || step) begin
            state_d  = S_FETCH;
            single_d = step;
          end
        end
        S_FETCH: state_d = S_WAIT;
        S_WAIT: begin
          op_d    = rom_data;
          state_d = S_EXEC;
        end
        S_EXEC: begin
          single_d = 1'b0;
          if (end_hit && !WRAP) begin
            state_d  = S_HALT;
            halted_d = 1'b1;
          end else begin
            pc_d    = end_hit ? 4'(nxt - LAST5 - 5'd1) : nxt[3:0];
            state_d = (run && !single_q) ? S_FETCH : S_IDLE;
          end
        end
        S_HALT:  state_d = S_HALT;
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign rom_addr   = pc_q;
  assign pc         = pc_q;
  assign op         = op_q;
  assign exec_valid = (state_q == S_EXEC);
  assign busy       = (state_q == S_FETCH) || (state_q == S_WAIT) || (state_q == S_EXEC);
  assign halted     = halted_q;

endmodule

// File: doc/program_sequencer.md
# program_sequencer

Fetch/sequence controller for the 4-bit accumulator core. Owns the program counter and drives the address of the synchronous (1-cycle latency) program ROM. Latches each fetched opcode into an instruction register and issues one execute strobe per instruction to the datapath. Resolves the skip-if-nonzero opcodes internally, and provides run, single-step, restart and end-of-program halt control.

## Interface
Parameters:
- LAST_ADDR, 15: highest program address executed; range 0..15.
- WRAP, 1: 1 = continue at address 0 after LAST_ADDR; 0 = halt after LAST_ADDR.
- SNZA_OP, 4'b1000: opcode meaning "skip next if A ≠ 0".
- SNZS_OP, 4'b1001: opcode meaning "skip next if S ≠ 0".

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- run  in  1  level; while high, instructions execute back-to-back.
- step  in  1  one-cycle pulse; executes exactly one instruction when idle.
- restart  in  1  synchronous; aborts any instruction, pc←0, state IDLE, clears halted.
- zero_a  in  1  datapath flag: register A == 0.
- zero_s  in  1  datapath flag: register S == 0.
- rom_addr  out  4  ROM address; equals pc.
- rom_data  in  4  ROM output, valid the cycle after rom_addr is presented.
- op  out  4  instruction register.
- exec_valid  out  1  one-cycle execute strobe for op.
- pc  out  4  program counter.
- busy  out  1  high in FETCH, WAIT and EXEC.
- halted  out  1  end-of-program halt flag (WRAP=0 only).

## Operation
- States: IDLE, FETCH, WAIT, EXEC, HALT.
- IDLE: if restart, stay. Otherwise, if run or step is sampled high, go to FETCH; a step pulse sets an internal single-shot flag.
- FETCH: rom_addr=pc. Always goes to WAIT.
- WAIT: ROM output becomes valid; op←rom_data at the closing edge. Go to EXEC.
- EXEC: exec_valid=1. Compute the next pc and the next state:
  - skip = (op==SNZA_OP && !zero_a) || (op==SNZS_OP && !zero_s).
  - The flags are sampled during EXEC.
  - Skip opcodes still pulse exec_valid; the datapath treats them as NOP.
  - nxt = pc + (skip ? 2 : 1), computed 5 bits wide.
  - If nxt > LAST_ADDR: with WRAP=1, pc←nxt−(LAST_ADDR+1); with WRAP=0, go to HALT and set halted=1, pc unchanged.
  - Otherwise pc←nxt.
  - Next state: FETCH if run is high and the single-shot flag is clear; else IDLE, clearing the flag.
- HALT: remains until restart. run and step are ignored.
- restart has priority over run/step/EXEC update in every state. When asserted during EXEC, exec_valid still shows this cycle, but pc←0, not nxt.
- run dropping mid-instruction: the current instruction completes, then IDLE.
- step while busy: ignored.

## Timing
- Reset values:
  - state IDLE; pc=0, rom_addr=0.
  - op=4'b0111 (CLR/NOP), exec_valid=0.
  - busy=0, halted=0, single-shot flag clear.
- 3 cycles per instruction (FETCH, WAIT, EXEC); free-run throughput is 1 exec_valid every 3 cycles.
- Latency: run sampled high at edge k gives FETCH in cycle k+1 and exec_valid in cycle k+3.
- op is stable from the WAIT→EXEC edge until the next WAIT→EXEC edge.
- pc updates on the EXEC closing edge; rom_addr follows combinationally.
- Reset asserted mid-instruction: all outputs return to their reset values immediately; no partial exec_valid.

## Test plan
- Reset: assert rst_n=0 mid-EXEC → exec_valid drops immediately; pc=0, op=0111, busy=0, halted=0.
- Free-run, ROM 0:0000, 1:0001, 2:1010, 3:0010, rest 0111, run=1 → exec_valid at cycles 3, 6, 9, 12 with op 0000, 0001, 1010, 0010. pc runs 0..15, then 0 (wrap).
- Skip: SNZA_OP at address 6, zero_a=0 → the next op comes from address 8. Same with zero_a=1 → address 7. SNZA at address 15, zero_a=0 → pc=1.
- Step: run=0, two step pulses 5 cycles apart → exactly two exec_valid, ops from addresses 0 and 1; busy low between; a step during busy is ignored.
- Halt: WRAP=0, LAST_ADDR=7, run=1 → after address 7 executes, halted=1, state HALT, no further exec_valid. restart → pc=0, halted=0.
- Restart priority: restart pulse in WAIT with run=1 → no exec_valid, pc=0, IDLE next cycle; then FETCH of address 0.
